ghash_digit_serial_core: RTL

GHASH_DIGIT_SERIAL_CORE -- requirements
Module: ghash_digit_serial_core

---
 rtl/ghash_digit_serial_core.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ghash_digit_serial_core.sv
// Digit-serial GHASH core: Y_i = (Y_(i-1) ^ X_i) * H over GF(2^128), NB_DIGIT multiplier bits per cycle.
// Optional sticky sequencing checker enabled by `define GHASH_CORE_PROTOCOL_CHECK_EN.
module ghash_digit_serial_core #(
  parameter int NB_BLOCK = 128,
  parameter int NB_DIGIT = 8
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NB_BLOCK-1:0] i_data,
  input  logic                i_sop,
  input  logic                i_eop,
  input  logic [NB_BLOCK-1:0] i_hash_subkey,
  output logic                o_valid,
  input  logic                i_ready,
`ifdef GHASH_CORE_PROTOCOL_CHECK_EN
  output logic                o_protocol_err,
`endif
  output logic [NB_BLOCK-1:0] o_ghash
);

  localparam int N_CYCLES = NB_BLOCK / NB_DIGIT;
  localparam int CW       = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;
  localparam logic [NB_BLOCK-1:0] R_POLY = {8'hE1, {(NB_BLOCK-8){1'b0}}};

  generate
    if (NB_BLOCK != 128 ||
        !(NB_DIGIT == 1  || NB_DIGIT == 2  || NB_DIGIT == 4  || NB_DIGIT == 8 ||
          NB_DIGIT == 16 || NB_DIGIT == 32 || NB_DIGIT == 64 || NB_DIGIT == 128)) begin : g_bad_param
      $error("ghash_digit_serial_core: illegal NB_BLOCK/NB_DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [NB_BLOCK-1:0] r_op, r_z, r_v, r_h, r_acc;
  logic [NB_BLOCK-1:0] w_z, w_v;
  logic [CW-1:0]       r_cnt;
  logic                r_eop;
  logic                w_last;

  assign w_last = (r_cnt == CW'(N_CYCLES-1));

  // Shift-right multiplier unrolled NB_DIGIT times; operand MSB is the x^0 coefficient.
  always_comb begin
    w_z = r_z;
    w_v = r_v;
    for (int i = 0; i < NB_DIGIT; i++) begin
      if (r_op[NB_BLOCK-1-i]) w_z = w_z ^ w_v;
      w_v = w_v[0] ? ((w_v >> 1) ^ R_POLY) : (w_v >> 1);
    end
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next = S_MULT;
      end
      S_MULT: if (w_last) w_next = r_eop ? S_DONE : S_IDLE;
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_op  <= '0;
      r_z   <= '0;
      r_v   <= '0;
      r_h   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_eop <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_valid) begin
          // A sop beat restarts from Y_0 = 0 with the new subkey; otherwise chain.
          r_op  <= (i_sop ? '0 : r_acc) ^ i_data;
          r_h   <= i_sop ? i_hash_subkey : r_h;
          r_v   <= i_sop ? i_hash_subkey : r_h;
          r_z   <= '0;
          r_eop <= i_eop;
          r_cnt <= '0;
        end
        S_MULT: begin
          r_z   <= w_z;
          r_v   <= w_v;
          r_op  <= r_op << NB_DIGIT;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_acc <= w_z;
        end
        default: ;
      endcase
    end
  end

  assign o_ghash = r_acc;

`ifdef GHASH_CORE_PROTOCOL_CHECK_EN
  logic r_open, r_perr;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_open <= 1'b0;
      r_perr <= 1'b0;
    end else if (r_state == S_IDLE && i_valid) begin
      r_open <= ~i_eop;
      if (i_sop == r_open) r_perr <= 1'b1;
    end
  end

  assign o_protocol_err = r_perr;
`endif

endmodule
